// File: rtl/audio_pkg.sv
// Shared audio definitions for the pedal board, the I2S DAC transmitter and
// the ADC-side receiver: sample type and default serial-frame geometry.
package audio_pkg;

   localparam int SAMPLE_W    = 16;
   localparam int BITS_PER_CH = 32;
   localparam int BCLK_HALF   = 8;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   typedef struct packed {
      sample_t left;
      sample_t right;
   } sample_pair_t;

   // True for the channel slots that carry sample bits. Slot 0 is the
   // one-BCLK I2S delay after the word-clock edge; slots past the sample
   // width are padding.
   function automatic logic is_data_slot(input int slot, input int sample_w);
      return (slot >= 1) && (slot <= sample_w);
   endfunction

endpackage

// File: rtl/bclk_gen.sv
// Bit-clock divider: toggles AUD_BCLK every BCLK_HALF system clocks and flags
// the cycle on which BCLK is about to fall, which is when serial data moves.
module bclk_gen #(
   parameter int BCLK_HALF = audio_pkg::BCLK_HALF
) (
   input  logic Clk,
   input  logic Reset_n,
   output logic AUD_BCLK,
   output logic shift_evt
);
   import audio_pkg::*;

   localparam int CNT_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BCLK_HALF - 1);

   logic [CNT_W-1:0] div_cnt;
   logic             wrap;

   assign wrap = (div_cnt == CNT_LAST);

   // shift_evt is combinational so the serializer updates on the very edge
   // where BCLK goes 1 -> 0, keeping data and BCLK edges aligned.
   assign shift_evt = wrap & AUD_BCLK;

   // Half-period counter and BCLK toggle flop.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         div_cnt  <= '0;
         AUD_BCLK <= 1'b0;
      end else if (wrap) begin
         div_cnt  <= '0;
         AUD_BCLK <= ~AUD_BCLK;
      end else begin
         div_cnt  <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S transmitter toward the codec DAC. Accepts signed left/right sample
// pairs into a single-entry holding buffer, loads them into per-channel
// shift registers at each frame start and serializes them MSB-first with
// the standard one-BCLK delay after the LRCK edge. An empty buffer at frame
// start plays silence and raises a one-cycle Underrun pulse.
module i2s_dac_tx #(
   parameter int SAMPLE_W    = audio_pkg::SAMPLE_W,
   parameter int BITS_PER_CH = audio_pkg::BITS_PER_CH,
   parameter int BCLK_HALF   = audio_pkg::BCLK_HALF
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic [SAMPLE_W-1:0] Left_in,
   input  logic [SAMPLE_W-1:0] Right_in,
   input  logic                Sample_valid,
   output logic                Sample_ready,
   output logic                AUD_BCLK,
   output logic                AUD_DACLRCK,
   output logic                AUD_DACDAT,
   output logic                Underrun
);
   import audio_pkg::*;

   localparam int B_W = $clog2(2 * BITS_PER_CH);
   localparam logic [B_W-1:0] B_LAST = B_W'(2 * BITS_PER_CH - 1);
   localparam logic [B_W-1:0] B_HALF = B_W'(BITS_PER_CH);

   logic                       shift_evt;
   logic [B_W-1:0]             bit_cnt;
   logic [B_W-1:0]             bit_cnt_nxt;
   logic [B_W-1:0]             slot_nxt;
   logic                       right_nxt;
   logic                       frame_start;
   logic                       data_slot;
   logic                       accept;

   logic signed [SAMPLE_W-1:0] hold_left;
   logic signed [SAMPLE_W-1:0] hold_right;
   logic signed [SAMPLE_W-1:0] left_sr;
   logic signed [SAMPLE_W-1:0] right_sr;

   bclk_gen #(
      .BCLK_HALF (BCLK_HALF)
   ) u_bclk_gen (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .AUD_BCLK  (AUD_BCLK),
      .shift_evt (shift_evt)
   );

   // Sample_ready doubles as the holding-buffer empty flag.
   assign accept = Sample_valid & Sample_ready;

   // Position of the slot that begins at the next shift event.
   always_comb begin
      bit_cnt_nxt = (bit_cnt == B_LAST) ? '0 : bit_cnt + 1'b1;
      frame_start = shift_evt && (bit_cnt == B_LAST);
      right_nxt   = (bit_cnt_nxt >= B_HALF);
      slot_nxt    = right_nxt ? (bit_cnt_nxt - B_HALF) : bit_cnt_nxt;
      data_slot   = is_data_slot(int'(slot_nxt), SAMPLE_W);
   end

   // Holding-buffer occupancy. An accept on the frame-start cycle wins over
   // the drain because the buffer was empty then: that pair waits a frame.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         Sample_ready <= 1'b1;
      end else if (accept) begin
         Sample_ready <= 1'b0;
      end else if (frame_start) begin
         Sample_ready <= 1'b1;
      end
   end

   // Holding-buffer data; qualified by Sample_ready, so no reset needed.
   always_ff @(posedge Clk) begin
      if (accept) begin
         hold_left  <= Left_in;
         hold_right <= Right_in;
      end
   end

   // Slot counter, word clock, shift registers and serial data output.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         bit_cnt     <= B_LAST;
         AUD_DACLRCK <= 1'b0;
         AUD_DACDAT  <= 1'b0;
         Underrun    <= 1'b0;
         left_sr     <= '0;
         right_sr    <= '0;
      end else begin
         Underrun <= frame_start & Sample_ready;
         if (shift_evt) begin
            bit_cnt     <= bit_cnt_nxt;
            AUD_DACLRCK <= right_nxt;
            if (frame_start) begin
               AUD_DACDAT <= 1'b0;
               if (!Sample_ready) begin
                  left_sr  <= hold_left;
                  right_sr <= hold_right;
               end else begin
                  left_sr  <= '0;
                  right_sr <= '0;
               end
            end else if (data_slot) begin
               if (right_nxt) begin
                  AUD_DACDAT <= right_sr[SAMPLE_W-1];
                  right_sr   <= {right_sr[SAMPLE_W-2:0], 1'b0};
               end else begin
                  AUD_DACDAT <= left_sr[SAMPLE_W-1];
                  left_sr    <= {left_sr[SAMPLE_W-2:0], 1'b0};
               end
            end else begin
               AUD_DACDAT <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: reset timing, single pair, starvation,
// back-to-back streaming, frame-start collision and mid-frame reset.
module tb_i2s_dac_tx;

   localparam int SW   = 16;
   localparam int BPC  = 32;
   localparam int HALF = 8;
   localparam int FRAME_CYC = 2 * BPC * 2 * HALF;
   localparam int FALL_LIMIT = 4 * HALF + 4;

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic [SW-1:0] Left_in = '0;
   logic [SW-1:0] Right_in = '0;
   logic          Sample_valid = 1'b0;
   logic          Sample_ready;
   logic          AUD_BCLK;
   logic          AUD_DACLRCK;
   logic          AUD_DACDAT;
   logic          Underrun;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int acc_cnt = 0;
   int acc_cyc [32];
   int acc_base;

   i2s_dac_tx #(
      .SAMPLE_W    (SW),
      .BITS_PER_CH (BPC),
      .BCLK_HALF   (HALF)
   ) dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .Left_in      (Left_in),
      .Right_in     (Right_in),
      .Sample_valid (Sample_valid),
      .Sample_ready (Sample_ready),
      .AUD_BCLK     (AUD_BCLK),
      .AUD_DACLRCK  (AUD_DACLRCK),
      .AUD_DACDAT   (AUD_DACDAT),
      .Underrun     (Underrun)
   );

   always #10 Clk = ~Clk;

   // Cycle counter and log of every accepted handshake.
   always @(posedge Clk) begin
      cyc <= cyc + 1;
      if (Sample_valid && Sample_ready) begin
         if (acc_cnt < 32) acc_cyc[acc_cnt] <= cyc;
         acc_cnt <= acc_cnt + 1;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance to the first negedge after the next BCLK falling edge.
   task automatic wait_fall();
      int n;
      n = 0;
      while (AUD_BCLK !== 1'b1 && n < FALL_LIMIT) begin
         @(negedge Clk);
         n++;
      end
      while (AUD_BCLK !== 1'b0 && n < FALL_LIMIT) begin
         @(negedge Clk);
         n++;
      end
      if (n >= FALL_LIMIT) check_val("bclk_fall_timeout", n, 0);
   endtask

   // Check slots first..last of a frame against the expected words.
   task automatic run_frame(input int first, input int last, input logic [SW-1:0] l,
                            input logic [SW-1:0] r, input logic exp_und);
      logic [SW-1:0] w;
      int            k;
      logic          exp_b;
      for (int s = first; s <= last; s++) begin
         wait_fall();
         w = (s < BPC) ? l : r;
         k = s % BPC;
         exp_b = (k >= 1 && k <= SW) ? w[SW-k] : 1'b0;
         check_val($sformatf("dat_s%0d", s), AUD_DACDAT, exp_b);
         check_val($sformatf("lrck_s%0d", s), AUD_DACLRCK, (s >= BPC));
         if (s == 0) begin
            check_val("underrun_at_start", Underrun, exp_und);
            @(negedge Clk);
            check_val("underrun_one_cycle", Underrun, 0);
         end
      end
   endtask

   // Present one pair for a single cycle; it must be taken.
   task automatic offer(input logic [SW-1:0] l, input logic [SW-1:0] r);
      check_val("ready_before_offer", Sample_ready, 1);
      Left_in = l;
      Right_in = r;
      Sample_valid = 1'b1;
      @(negedge Clk);
      Sample_valid = 1'b0;
      Left_in = 16'($urandom);
      Right_in = 16'($urandom);
      check_val("ready_after_offer", Sample_ready, 0);
   endtask

   // Hold reset 10 cycles, check reset outputs, release and check the
   // first BCLK rise/fall and the first (empty) frame start.
   task automatic reset_seq();
      Reset_n = 1'b0;
      repeat (10) @(negedge Clk);
      check_val("rst_bclk", AUD_BCLK, 0);
      check_val("rst_lrck", AUD_DACLRCK, 0);
      check_val("rst_dat", AUD_DACDAT, 0);
      check_val("rst_ready", Sample_ready, 1);
      check_val("rst_underrun", Underrun, 0);
      Reset_n = 1'b1;
      for (int c = 1; c <= 2 * HALF; c++) begin
         @(negedge Clk);
         if (c == HALF - 1)     check_val("bclk_low_c7", AUD_BCLK, 0);
         if (c == HALF)         check_val("bclk_rise_c8", AUD_BCLK, 1);
         if (c == 2 * HALF - 1) begin
            check_val("bclk_high_c15", AUD_BCLK, 1);
            check_val("underrun_c15", Underrun, 0);
         end
         if (c == 2 * HALF) begin
            check_val("bclk_fall_c16", AUD_BCLK, 0);
            check_val("underrun_c16", Underrun, 1);
            check_val("lrck_c16", AUD_DACLRCK, 0);
            check_val("dat_c16", AUD_DACDAT, 0);
         end
      end
   endtask

   initial begin
      // Reset and first frame, which underruns
      reset_seq();
      run_frame(1, 2 * BPC - 1, '0, '0, 1'b0);

      // Single pair: left 0100101011110011, right 1111101010001101
      offer(16'h4af3, 16'hfa8d);
      run_frame(0, 2 * BPC - 1, 16'h4af3, 16'hfa8d, 1'b0);

      // Starvation: two empty frames, one pulse each
      run_frame(0, 2 * BPC - 1, '0, '0, 1'b1);
      run_frame(0, 2 * BPC - 1, '0, '0, 1'b1);

      // Back-to-back: valid held high across three frame starts
      acc_base = acc_cnt;
      Left_in = 16'h0005;
      Right_in = 16'hfffb;
      Sample_valid = 1'b1;
      for (int f = 0; f < 3; f++) run_frame(0, 2 * BPC - 1, 16'h0005, 16'hfffb, 1'b0);
      Sample_valid = 1'b0;
      check_val("b2b_accepts", acc_cnt - acc_base, 4);
      check_val("b2b_spacing_1", acc_cyc[acc_base+2] - acc_cyc[acc_base+1], FRAME_CYC);
      check_val("b2b_spacing_2", acc_cyc[acc_base+3] - acc_cyc[acc_base+2], FRAME_CYC);
      run_frame(0, 2 * BPC - 1, 16'h0005, 16'hfffb, 1'b0);
      run_frame(0, 2 * BPC - 1, '0, '0, 1'b1);

      // Collision: valid on the frame-start cycle with holding empty
      repeat (2 * HALF - 1) @(negedge Clk);
      Left_in = 16'h8001;
      Right_in = 16'h7ffe;
      Sample_valid = 1'b1;
      @(negedge Clk);
      Sample_valid = 1'b0;
      check_val("collide_underrun", Underrun, 1);
      check_val("collide_ready", Sample_ready, 0);
      check_val("collide_bclk", AUD_BCLK, 0);
      run_frame(1, 2 * BPC - 1, '0, '0, 1'b0);

      // Following frame plays the pair; reset at right-channel slot 10
      run_frame(0, BPC + 10, 16'h8001, 16'h7ffe, 1'b0);
      offer(16'h1234, 16'h5678);
      check_val("mid_lrck", AUD_DACLRCK, 1);
      Reset_n = 1'b0;
      @(negedge Clk);
      check_val("midrst_bclk", AUD_BCLK, 0);
      check_val("midrst_lrck", AUD_DACLRCK, 0);
      check_val("midrst_dat", AUD_DACDAT, 0);
      check_val("midrst_ready", Sample_ready, 1);
      check_val("midrst_underrun", Underrun, 0);
      reset_seq();
      run_frame(1, 2 * BPC - 1, '0, '0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Absolute time bound for the whole run.
   initial begin
      #(20 * 20000);
      $display("FAIL global_timeout: cycle %0d reached, required finish before %0d", cyc, 20000);
      $fatal(1, "timeout");
   end

endmodule
